// File: rtl/dht_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dht_frame_ctrl
// Description : One DHT11 single-wire transaction: start pulse, 40-bit decode,
//               checksum, publish humidity/temperature. 10 us tick time base.
// Revision    : 1.0 - initial release
// ============================================================================
module dht_frame_ctrl #(
  parameter int START_TICKS   = 1800,
  parameter int TIMEOUT_TICKS = 20,
  parameter int BIT1_THRESH   = 5
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iTick,
  output logic        oTick_Run,
  output logic        oTick_Clear,
  input  logic        iDht,
  output logic        oDht_Drive_Low,
  output logic [15:0] oHumid,
  output logic [15:0] oTemp,
  output logic        oValid,
  output logic        oError,
  output logic [1:0]  oErr_Code,
  output logic        oBusy
);

  localparam int TW = $clog2(START_TICKS + 1);
  localparam logic [TW-1:0] c_startTicks   = TW'(START_TICKS);
  localparam logic [TW-1:0] c_timeoutTicks = TW'(TIMEOUT_TICKS);
  localparam logic [TW-1:0] c_bit1Thresh   = TW'(BIT1_THRESH);
  localparam logic [TW-1:0] c_tickMax      = '1;
  localparam logic [1:0]    c_errNone      = 2'b00;
  localparam logic [1:0]    c_errTimeout   = 2'b01;
  localparam logic [1:0]    c_errChecksum  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_WAIT_RESP = 4'd2,
    S_RESP_LOW  = 4'd3,
    S_RESP_HIGH = 4'd4,
    S_BIT_LOW   = 4'd5,
    S_BIT_HIGH  = 4'd6,
    S_CHECK     = 4'd7,
    S_DONE      = 4'd8,
    S_ERR       = 4'd9
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  logic [TW-1:0]   r_tickCnt;
  logic [5:0]      r_bitCnt;
  logic [39:0]     r_shift;

  logic            w_fall;
  logic            w_rise;
  logic            w_timeout;
  logic [7:0]      w_sum;

  assign w_fall    = r_prev & ~r_sync2;
  assign w_rise    = ~r_prev & r_sync2;
  assign w_timeout = (r_tickCnt >= c_timeoutTicks);
  assign w_sum     = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];

  // Every branch that changes r_state also zeroes r_tickCnt, overriding the increment.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state        <= S_IDLE;
      r_sync1        <= 1'b1;
      r_sync2        <= 1'b1;
      r_prev         <= 1'b1;
      r_tickCnt      <= '0;
      r_bitCnt       <= '0;
      r_shift        <= '0;
      oDht_Drive_Low <= 1'b0;
      oHumid         <= '0;
      oTemp          <= '0;
      oValid         <= 1'b0;
      oError         <= 1'b0;
      oErr_Code      <= c_errNone;
      oBusy          <= 1'b0;
      oTick_Run      <= 1'b0;
      oTick_Clear    <= 1'b1;
    end else begin
      r_sync1 <= iDht;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      oValid  <= 1'b0;
      oError  <= 1'b0;
      if (iTick && (r_tickCnt != c_tickMax))
        r_tickCnt <= r_tickCnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_state        <= S_START;
            r_tickCnt      <= '0;
            r_bitCnt       <= '0;
            r_shift        <= '0;
            oErr_Code      <= c_errNone;
            oBusy          <= 1'b1;
            oDht_Drive_Low <= 1'b1;
            oTick_Run      <= 1'b1;
            oTick_Clear    <= 1'b0;
          end
        end
        S_START: begin
          if (r_tickCnt == c_startTicks) begin
            r_state        <= S_WAIT_RESP;
            r_tickCnt      <= '0;
            oDht_Drive_Low <= 1'b0;
          end
        end
        S_WAIT_RESP: begin
          if (w_fall) begin
            r_state   <= S_RESP_LOW;
            r_tickCnt <= '0;
          end else if (w_timeout) begin
            r_state   <= S_ERR;
            r_tickCnt <= '0;
            oErr_Code <= c_errTimeout;
            oError    <= 1'b1;
          end
        end
        S_RESP_LOW: begin
          if (w_rise) begin
            r_state   <= S_RESP_HIGH;
            r_tickCnt <= '0;
          end else if (w_timeout) begin
            r_state   <= S_ERR;
            r_tickCnt <= '0;
            oErr_Code <= c_errTimeout;
            oError    <= 1'b1;
          end
        end
        S_RESP_HIGH: begin
          if (w_fall) begin
            r_state   <= S_BIT_LOW;
            r_tickCnt <= '0;
          end else if (w_timeout) begin
            r_state   <= S_ERR;
            r_tickCnt <= '0;
            oErr_Code <= c_errTimeout;
            oError    <= 1'b1;
          end
        end
        S_BIT_LOW: begin
          if (w_rise) begin
            r_state   <= S_BIT_HIGH;
            r_tickCnt <= '0;
          end else if (w_timeout) begin
            r_state   <= S_ERR;
            r_tickCnt <= '0;
            oErr_Code <= c_errTimeout;
            oError    <= 1'b1;
          end
        end
        S_BIT_HIGH: begin
          // High-time length decides the bit value, MSB first.
          if (w_fall) begin
            r_shift   <= {r_shift[38:0], (r_tickCnt >= c_bit1Thresh)};
            r_bitCnt  <= r_bitCnt + 1'b1;
            r_tickCnt <= '0;
            r_state   <= (r_bitCnt == 6'd39) ? S_CHECK : S_BIT_LOW;
          end else if (w_timeout) begin
            r_state   <= S_ERR;
            r_tickCnt <= '0;
            oErr_Code <= c_errTimeout;
            oError    <= 1'b1;
          end
        end
        S_CHECK: begin
          r_tickCnt <= '0;
          if (w_sum == r_shift[7:0]) begin
            r_state <= S_DONE;
            oHumid  <= r_shift[39:24];
            oTemp   <= r_shift[23:8];
            oValid  <= 1'b1;
          end else begin
            r_state   <= S_ERR;
            oErr_Code <= c_errChecksum;
            oError    <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          r_state     <= S_IDLE;
          r_tickCnt   <= '0;
          oBusy       <= 1'b0;
          oTick_Run   <= 1'b0;
          oTick_Clear <= 1'b1;
        end
        default: begin
          r_state        <= S_IDLE;
          r_tickCnt      <= '0;
          oBusy          <= 1'b0;
          oDht_Drive_Low <= 1'b0;
          oTick_Run      <= 1'b0;
          oTick_Clear    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dht_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dht_frame_ctrl
// Description : Directed self-checking bench for dht_frame_ctrl with a DHT11 line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dht_frame_ctrl;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStart;
  logic        iTick;
  logic        oTick_Run;
  logic        oTick_Clear;
  logic        iDht;
  logic        oDht_Drive_Low;
  logic [15:0] oHumid;
  logic [15:0] oTemp;
  logic        oValid;
  logic        oError;
  logic [1:0]  oErr_Code;
  logic        oBusy;

  int nChecks = 0;
  int nErrors = 0;

  dht_frame_ctrl #(
    .START_TICKS  (1800),
    .TIMEOUT_TICKS(20),
    .BIT1_THRESH  (5)
  ) dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iStart        (iStart),
    .iTick         (iTick),
    .oTick_Run     (oTick_Run),
    .oTick_Clear   (oTick_Clear),
    .iDht          (iDht),
    .oDht_Drive_Low(oDht_Drive_Low),
    .oHumid        (oHumid),
    .oTemp         (oTemp),
    .oValid        (oValid),
    .oError        (oError),
    .oErr_Code     (oErr_Code),
    .oBusy         (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic stepClk(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic pulseTick();
    iTick = 1'b1;
    stepClk(1);
    iTick = 1'b0;
    stepClk(1);
  endtask

  // Two sync flops plus the acting edge: the FSM has moved after 3 clocks.
  task automatic lineTo(input logic v);
    iDht = v;
    stepClk(3);
  endtask

  task automatic doStart();
    iStart = 1'b1;
    stepClk(1);
    iStart = 1'b0;
    repeat (1800) pulseTick();
  endtask

  task automatic sendResp();
    lineTo(1'b0);
    lineTo(1'b1);
    lineTo(1'b0);
  endtask

  task automatic sendBits(input logic [39:0] f, input int nBits, input int t0, input int t1);
    for (int i = 0; i < nBits; i++) begin
      lineTo(1'b1);
      repeat (f[39-i] ? t1 : t0) pulseTick();
      lineTo(1'b0);
    end
  endtask

  initial begin
    iRst   = 1'b1;
    iStart = 1'b0;
    iTick  = 1'b0;
    iDht   = 1'b1;
    stepClk(2);
    checkVal("rst_drive", oDht_Drive_Low, 0);
    checkVal("rst_run",   oTick_Run, 0);
    checkVal("rst_clear", oTick_Clear, 1);
    checkVal("rst_busy",  oBusy, 0);
    checkVal("rst_humid", oHumid, 0);
    checkVal("rst_code",  oErr_Code, 0);
    iRst = 1'b0;
    stepClk(1);

    // T1: start pulse length
    iStart = 1'b1;
    stepClk(1);
    iStart = 1'b0;
    checkVal("t1_drive_on", oDht_Drive_Low, 1);
    checkVal("t1_run",      oTick_Run, 1);
    checkVal("t1_clear",    oTick_Clear, 0);
    checkVal("t1_busy",     oBusy, 1);
    repeat (1799) pulseTick();
    checkVal("t1_drive_1799", oDht_Drive_Low, 1);
    iTick = 1'b1;
    stepClk(1);
    iTick = 1'b0;
    checkVal("t1_drive_1800", oDht_Drive_Low, 1);
    stepClk(1);
    checkVal("t1_released", oDht_Drive_Low, 0);
    checkVal("t1_busy_wait", oBusy, 1);

    // T2: good frame
    sendResp();
    sendBits(40'h37_00_1A_05_56, 40, 2, 7);
    stepClk(1);
    checkVal("t2_valid", oValid, 1);
    checkVal("t2_error", oError, 0);
    checkVal("t2_humid", oHumid, 16'h3700);
    checkVal("t2_temp",  oTemp, 16'h1A05);
    checkVal("t2_code",  oErr_Code, 0);
    checkVal("t2_busy_done", oBusy, 1);
    stepClk(1);
    checkVal("t2_valid_pulse", oValid, 0);
    checkVal("t2_busy_fall", oBusy, 0);
    checkVal("t2_clear_idle", oTick_Clear, 1);
    lineTo(1'b1);

    // T3: bad checksum
    doStart();
    sendResp();
    sendBits(40'h37_00_1A_05_57, 40, 2, 7);
    stepClk(1);
    checkVal("t3_error", oError, 1);
    checkVal("t3_valid", oValid, 0);
    checkVal("t3_code",  oErr_Code, 2'b10);
    checkVal("t3_humid", oHumid, 16'h3700);
    checkVal("t3_temp",  oTemp, 16'h1A05);
    stepClk(1);
    checkVal("t3_error_pulse", oError, 0);
    checkVal("t3_code_held", oErr_Code, 2'b10);
    checkVal("t3_busy_fall", oBusy, 0);
    lineTo(1'b1);

    // T4: no response, timeout after 20 ticks
    iStart = 1'b1;
    stepClk(1);
    iStart = 1'b0;
    checkVal("t4_code_cleared", oErr_Code, 0);
    repeat (1800) pulseTick();
    repeat (19) pulseTick();
    checkVal("t4_no_err_19", oError, 0);
    iTick = 1'b1;
    stepClk(1);
    iTick = 1'b0;
    checkVal("t4_no_err_20", oError, 0);
    stepClk(1);
    checkVal("t4_error", oError, 1);
    checkVal("t4_code",  oErr_Code, 2'b01);
    checkVal("t4_drive", oDht_Drive_Low, 0);
    stepClk(1);
    checkVal("t4_busy_fall", oBusy, 0);

    // T5: 4-tick zeros, 5-tick ones; last bit edge coincides with timeout
    doStart();
    sendResp();
    sendBits(40'h01_02_03_05_0B, 39, 4, 5);
    lineTo(1'b1);
    repeat (19) pulseTick();
    iDht = 1'b0;
    stepClk(1);
    iTick = 1'b1;
    stepClk(1);
    iTick = 1'b0;
    stepClk(1);
    stepClk(1);
    checkVal("t5_valid", oValid, 1);
    checkVal("t5_error", oError, 0);
    checkVal("t5_humid", oHumid, 16'h0102);
    checkVal("t5_temp",  oTemp, 16'h0305);
    stepClk(1);
    lineTo(1'b1);

    // T6: iStart while busy is ignored; reset mid-frame
    iStart = 1'b1;
    stepClk(1);
    iStart = 1'b0;
    repeat (1000) pulseTick();
    iStart = 1'b1;
    stepClk(1);
    iStart = 1'b0;
    repeat (799) pulseTick();
    checkVal("t6_drive_1799", oDht_Drive_Low, 1);
    pulseTick();
    checkVal("t6_released", oDht_Drive_Low, 0);
    sendResp();
    sendBits(40'hA5_00_00_00_00, 10, 2, 7);
    lineTo(1'b1);
    repeat (3) pulseTick();
    iRst = 1'b1;
    #1;
    checkVal("t6_rst_drive", oDht_Drive_Low, 0);
    checkVal("t6_rst_busy",  oBusy, 0);
    checkVal("t6_rst_run",   oTick_Run, 0);
    checkVal("t6_rst_clear", oTick_Clear, 1);
    checkVal("t6_rst_humid", oHumid, 0);
    checkVal("t6_rst_temp",  oTemp, 0);
    checkVal("t6_rst_code",  oErr_Code, 0);
    stepClk(1);
    iRst = 1'b0;
    stepClk(2);
    doStart();
    sendResp();
    sendBits(40'h37_00_1A_05_56, 40, 2, 7);
    stepClk(1);
    checkVal("t6_clean_valid", oValid, 1);
    checkVal("t6_clean_humid", oHumid, 16'h3700);
    checkVal("t6_clean_temp",  oTemp, 16'h1A05);
    stepClk(1);
    checkVal("t6_clean_busy", oBusy, 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
